// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix scanner: width helper, FSM
// encodings and the layout of queued key events.
package keypad_pkg;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  typedef enum logic {
    ST_SCAN   = 1'b0,
    ST_UPDATE = 1'b1
  } scan_state_t;

  // Event words are {press, code}: the press flag sits directly above the key index.
  function automatic int ev_width(input int key_w);
    return key_w + 1;
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// First-word fall-through event queue; a push that finds it full (with no
// same-cycle pop) is discarded and flagged for one cycle.
module kp_event_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_drop
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_drop;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_valid = !w_empty;
  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_drop  = r_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= i_push && !w_push;
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Strobes an active-low column across an R x C key matrix, debounces every key
// independently and queues press/release events for the front-panel logic.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int KEY_W     = clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col,
  output logic [ROWS*COLS-1:0] pressed,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [KEY_W-1:0]     ev_code,
  output logic                 ev_press,
  output logic                 ev_overflow
);
  localparam int NKEYS  = ROWS * COLS;
  localparam int RIDX_W = clog2(ROWS);
  localparam int CIDX_W = clog2(COLS);
  localparam int DIV_W  = clog2(SCAN_DIV);
  localparam int EV_W   = ev_width(KEY_W);

  logic [CIDX_W-1:0] r_cidx;
  logic [DIV_W-1:0]  r_div;
  logic [ROWS-1:0]   r_sample;
  logic [CIDX_W-1:0] r_scol;
  scan_state_t       r_state;
  logic [RIDX_W-1:0] r_ridx;
  logic [3:0]        r_cnt [NKEYS];
  logic [NKEYS-1:0]  r_pressed;

  logic              w_sample_now;
  logic [KEY_W-1:0]  w_key;
  logic              w_hit;
  logic [3:0]        w_cnt_next;
  logic              w_flip;
  logic [EV_W-1:0]   w_ev_word;
  logic [EV_W-1:0]   w_head;
  logic              w_full;

  assign col          = ~(COLS'(1) << r_cidx);
  assign pressed      = r_pressed;
  assign w_sample_now = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_key        = KEY_W'(r_ridx) * KEY_W'(COLS) + KEY_W'(r_scol);
  assign w_hit        = r_sample[r_ridx];
  assign w_cnt_next   = r_cnt[w_key] + 4'd1;
  assign w_flip       = (r_state == ST_UPDATE) && (w_hit != r_pressed[w_key]) &&
                        (w_cnt_next == 4'(DEBOUNCE));
  assign w_ev_word    = {w_hit, w_key};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cidx    <= '0;
      r_div     <= '0;
      r_state   <= ST_SCAN;
      r_ridx    <= '0;
      r_pressed <= '0;
      for (int k = 0; k < NKEYS; k++) r_cnt[k] <= 4'd0;
    end else begin
      if (w_sample_now) begin
        r_div    <= '0;
        r_sample <= ~row;
        r_scol   <= r_cidx;
        r_cidx   <= (r_cidx == CIDX_W'(COLS - 1)) ? '0 : r_cidx + CIDX_W'(1);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      case (r_state)
        ST_SCAN: begin
          if (w_sample_now) begin
            r_state <= ST_UPDATE;
            r_ridx  <= '0;
          end
        end
        ST_UPDATE: begin
          // One key of the sampled column per cycle, ascending row order.
          if (w_hit == r_pressed[w_key]) begin
            r_cnt[w_key] <= 4'd0;
          end else if (w_flip) begin
            r_cnt[w_key]     <= 4'd0;
            r_pressed[w_key] <= w_hit;
          end else begin
            r_cnt[w_key] <= w_cnt_next;
          end
          if (r_ridx == RIDX_W'(ROWS - 1)) r_state <= ST_SCAN;
          else r_ridx <= r_ridx + RIDX_W'(1);
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  kp_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_flip),
    .i_wdata (w_ev_word),
    .i_pop   (ev_ready),
    .o_rdata (w_head),
    .o_valid (ev_valid),
    .o_full  (w_full),
    .o_drop  (ev_overflow)
  );

  assign ev_press = w_head[KEY_W];
  assign ev_code  = w_head[KEY_W-1:0];

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a matrix model closes rows under
// the driven column; a monitor pops expected events as the DUT hands them out.
module tb_keypad_matrix_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic        ev_overflow;

  logic [15:0] held = 16'h0000;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ovf_cnt = 0;
  int          t0 = 0;
  logic [4:0]  sb [$];
  int          pop_t [$];
  logic [4:0]  m_exp;

  keypad_matrix_scanner #(
    .ROWS (ROWS), .COLS (COLS), .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk), .reset (reset), .row (row), .col (col), .pressed (pressed),
    .ev_valid (ev_valid), .ev_ready (ev_ready), .ev_code (ev_code),
    .ev_press (ev_press), .ev_overflow (ev_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!col[c] && held[r*COLS+c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ev_overflow) ovf_cnt++;
      if (ev_valid && ev_ready) begin
        total++;
        pop_t.push_back(cyc);
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event actual press=%0d code=%0d required none",
                   ev_press, ev_code);
        end else begin
          m_exp = sb.pop_front();
          if ({ev_press, ev_code} !== m_exp) begin
            bad++;
            $display("FAIL event actual press=%0d code=%0d required press=%0d code=%0d",
                     ev_press, ev_code, m_exp[4], m_exp[3:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns on the first negedge of the column-3 dwell (div just wrapped to 0).
  task automatic align_col3();
    int n;
    n = 0;
    while (col !== 4'b1011 && n < 100) begin @(negedge clk); n++; end
    while (col !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL align_col3 actual=%b required=0111", col);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h0e);
    check("rst_pressed", 32'(pressed), 32'h0);
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_head", 32'({ev_press, ev_code}), 32'h0);
    check("rst_ovf", 32'(ev_overflow), 32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_col1", 32'(col), 32'h0d);
    repeat (8) @(negedge clk);
    check("idle_col2", 32'(col), 32'h0b);
    repeat (8) @(negedge clk);
    check("idle_col3", 32'(col), 32'h07);
    repeat (8) @(negedge clk);
    check("idle_col0", 32'(col), 32'h0e);
    repeat (32) @(negedge clk);
    check("idle_pressed", 32'(pressed), 32'h0);
    check("idle_valid", 32'(ev_valid), 32'h0);

    // Key 11 press: first sample 7 cycles in, third 64 later, row 2 lands at +75.
    ev_ready = 1'b1;
    align_col3();
    t0 = cyc;
    pop_t.delete();
    held = 16'h0800;
    sb.push_back({1'b1, 4'd11});
    repeat (128) @(negedge clk);
    check("k11_drained", 32'(sb.size()), 32'd0);
    check("k11_pressed", 32'(pressed), 32'h0800);
    check("k11_count", 32'(pop_t.size()), 32'd1);
    check("k11_latency", 32'(pop_t.size() > 0 ? pop_t[0] - t0 : -1), 32'd75);

    align_col3();
    t0 = cyc;
    pop_t.delete();
    held = 16'h0000;
    sb.push_back({1'b0, 4'd11});
    repeat (128) @(negedge clk);
    check("k11r_drained", 32'(sb.size()), 32'd0);
    check("k11r_pressed", 32'(pressed), 32'h0);
    check("k11r_latency", 32'(pop_t.size() > 0 ? pop_t[0] - t0 : -1), 32'd75);

    // Key 5 held for only two samples.
    align_col3();
    held = 16'h0020;
    repeat (64) @(negedge clk);
    check("bounce_mid", 32'(pressed), 32'h0);
    held = 16'h0000;
    repeat (128) @(negedge clk);
    check("bounce_pressed", 32'(pressed), 32'h0);

    // Keys 1 and 9 share column 1.
    align_col3();
    t0 = cyc;
    pop_t.delete();
    held = 16'h0202;
    sb.push_back({1'b1, 4'd1});
    sb.push_back({1'b1, 4'd9});
    repeat (128) @(negedge clk);
    check("pair_drained", 32'(sb.size()), 32'd0);
    check("pair_pressed", 32'(pressed), 32'h0202);
    check("pair_count", 32'(pop_t.size()), 32'd2);
    check("pair_first", 32'(pop_t.size() > 0 ? pop_t[0] - t0 : -1), 32'd89);
    check("pair_gap", 32'(pop_t.size() > 1 ? pop_t[1] - pop_t[0] : -1), 32'd2);
    align_col3();
    held = 16'h0000;
    sb.push_back({1'b0, 4'd1});
    sb.push_back({1'b0, 4'd9});
    repeat (128) @(negedge clk);
    check("pairr_drained", 32'(sb.size()), 32'd0);
    check("pairr_pressed", 32'(pressed), 32'h0);

    // Consumer stalled: keys 0,1 fill the queue, key 2 is dropped.
    ev_ready = 1'b0;
    align_col3();
    ovf_cnt = 0;
    held = 16'h0007;
    sb.push_back({1'b1, 4'd0});
    sb.push_back({1'b1, 4'd1});
    repeat (128) @(negedge clk);
    check("ovf_pressed", 32'(pressed), 32'h0007);
    check("ovf_pulses", 32'(ovf_cnt), 32'd1);
    check("ovf_valid", 32'(ev_valid), 32'h1);
    check("ovf_head", 32'({ev_press, ev_code}), 32'h10);
    check("ovf_pending", 32'(sb.size()), 32'd2);
    ev_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovf_drained", 32'(sb.size()), 32'd0);
    check("ovf_empty", 32'(ev_valid), 32'h0);
    align_col3();
    held = 16'h0000;
    sb.push_back({1'b0, 4'd0});
    sb.push_back({1'b0, 4'd1});
    sb.push_back({1'b0, 4'd2});
    repeat (128) @(negedge clk);
    check("ovfr_drained", 32'(sb.size()), 32'd0);
    check("ovfr_pressed", 32'(pressed), 32'h0);
    check("ovfr_pulses", 32'(ovf_cnt), 32'd1);

    // Reset lands in the UPDATE cycle that would flip key 4 (row 1, column 0).
    align_col3();
    held = 16'h0010;
    repeat (81) @(negedge clk);
    check("rstupd_pre", 32'(pressed), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    held = 16'h0000;
    check("rstupd_col", 32'(col), 32'h0e);
    check("rstupd_pressed", 32'(pressed), 32'h0);
    check("rstupd_valid", 32'(ev_valid), 32'h0);
    repeat (128) @(negedge clk);
    check("rstupd_after", 32'(pressed), 32'h0);
    check("rstupd_quiet", 32'(ev_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
